// File: rtl/intctl85_pkg.sv
// Shared constants for the 8085-class interrupt controller: source encoding,
// default vector addresses and the RST vector helper.
package intctl85_pkg;

  localparam int unsigned SRC_W = 4;

  localparam logic [SRC_W-1:0] SRC_NONE = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_TRAP = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_INTR = SRC_W'(2);
  localparam logic [SRC_W-1:0] SRC_RST0 = SRC_W'(3);

  localparam logic [15:0] TRAP_VEC_DEF = 16'h0024;
  localparam logic [15:0] RST_BASE_DEF = 16'h002C;
  localparam int unsigned RST_STEP_DEF = 8;

  // Vector of RST line idx; the caller truncates to its address width.
  function automatic logic [31:0] rst_vector(input logic [31:0] base,
                                             input int unsigned step,
                                             input int unsigned idx);
    return base + 32'(step * idx);
  endfunction

endpackage

// File: rtl/intctl85_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin followed by a one-flop
// rising-edge detector; level_s is the detector flop output.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      level_s <= 1'b0;
    end else begin
      q       <= {q[SYNC_STAGES-2:0], d};
      level_s <= q[SYNC_STAGES-1];
    end
  end

  // Rise is seen one cycle before level_s so latched and level paths align.
  assign rise = q[SYNC_STAGES-1] & ~level_s;

endmodule

// File: rtl/intctl85.sv
// Interrupt and serial-pin controller: TRAP, vectored RST lines, INTR,
// SIM/RIM mask and status, SID/SOD; presents one registered request.
module intctl85
  import intctl85_pkg::*;
#(
  parameter int unsigned         NUM_RST     = 3,
  parameter logic [NUM_RST-1:0]  EDGE_MASK   = NUM_RST'(3'b100),
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         ADDRSIZE    = 16,
  parameter logic [ADDRSIZE-1:0] TRAP_VEC    = ADDRSIZE'(TRAP_VEC_DEF),
  parameter logic [ADDRSIZE-1:0] RST_BASE    = ADDRSIZE'(RST_BASE_DEF),
  parameter int unsigned         RST_STEP    = RST_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trap,
  input  logic [NUM_RST-1:0]  rst_in,
  input  logic                intr,
  input  logic                sid,
  input  logic                inst_done,
  input  logic                ei,
  input  logic                di,
  input  logic                mask_wr,
  input  logic [NUM_RST-1:0]  mask_in,
  input  logic [NUM_RST-1:0]  edge_clr,
  input  logic                sod_wr,
  input  logic                sod_in,
  input  logic                ack,
  output logic                irq,
  output logic [ADDRSIZE-1:0] irq_vec,
  output logic                irq_intr,
  output logic                ie,
  output logic                ie_saved,
  output logic [NUM_RST-1:0]  mask,
  output logic [NUM_RST-1:0]  pending,
  output logic                sid_s,
  output logic                sod
);

  logic               trap_lvl, trap_rise;
  logic               intr_lvl, intr_rise_unused;
  logic               sid_lvl, sid_rise_unused;
  logic [NUM_RST-1:0] rst_lvl, rst_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trap (
    .clk(clk), .rst(rst), .d(trap), .level_s(trap_lvl), .rise(trap_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_intr (
    .clk(clk), .rst(rst), .d(intr), .level_s(intr_lvl), .rise(intr_rise_unused));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sid (
    .clk(clk), .rst(rst), .d(sid), .level_s(sid_lvl), .rise(sid_rise_unused));

  for (genvar g = 0; g < NUM_RST; g++) begin : g_rst
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(rst_in[g]), .level_s(rst_lvl[g]), .rise(rst_rise[g]));
  end

  logic [NUM_RST-1:0] latch;
  logic               trap_latch;
  logic               arm;
  logic [SRC_W-1:0]   irq_src;

  logic                ack_fire_c, trap_ack_c, ie_eff_c;
  logic [NUM_RST-1:0]  rst_ack_c, clr_c, avail_c, elig_c;
  logic [SRC_W-1:0]    win_src_c;
  logic [ADDRSIZE-1:0] win_vec_c;
  logic                win_intr_c;
  logic                ie_n_c, arm_n_c;

  // Acknowledge decode, eligibility and priority resolution for the next request.
  always_comb begin
    ack_fire_c = ack & irq;
    trap_ack_c = ack_fire_c & (irq_src == SRC_TRAP);
    ie_eff_c   = ie & ~ack_fire_c & ~di;
    rst_ack_c  = '0;
    for (int unsigned i = 0; i < NUM_RST; i++) begin
      rst_ack_c[i] = ack_fire_c & (irq_src == SRC_W'(i + 32'(SRC_RST0)));
    end
    clr_c   = EDGE_MASK & (rst_ack_c | (mask_wr ? edge_clr : '0));
    avail_c = (EDGE_MASK & latch & ~clr_c) | (~EDGE_MASK & rst_lvl);
    elig_c  = avail_c & ~mask & {NUM_RST{ie_eff_c}};

    win_src_c  = SRC_NONE;
    win_vec_c  = '0;
    win_intr_c = 1'b0;
    if (intr_lvl & ie_eff_c) begin
      win_src_c  = SRC_INTR;
      win_intr_c = 1'b1;
    end
    // Ascending scan: the highest eligible line overrides lower ones.
    for (int unsigned i = 0; i < NUM_RST; i++) begin
      if (elig_c[i]) begin
        win_src_c  = SRC_W'(i + 32'(SRC_RST0));
        win_vec_c  = ADDRSIZE'(rst_vector(32'(RST_BASE), RST_STEP, i));
        win_intr_c = 1'b0;
      end
    end
    if (trap_latch & trap_lvl & ~trap_ack_c) begin
      win_src_c  = SRC_TRAP;
      win_vec_c  = TRAP_VEC;
      win_intr_c = 1'b0;
    end
  end

  // Interrupt-enable sequencing: EI arms, next instruction boundary enables.
  always_comb begin
    ie_n_c  = ie;
    arm_n_c = arm;
    if (arm & inst_done) begin
      ie_n_c  = 1'b1;
      arm_n_c = 1'b0;
    end
    if (ei)         arm_n_c = 1'b1;
    if (ack_fire_c) ie_n_c  = 1'b0;
    if (di) begin
      ie_n_c  = 1'b0;
      arm_n_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch      <= '0;
      trap_latch <= 1'b0;
      arm        <= 1'b0;
      ie         <= 1'b0;
      ie_saved   <= 1'b0;
      mask       <= '1;
      sod        <= 1'b0;
      irq        <= 1'b0;
      irq_vec    <= '0;
      irq_intr   <= 1'b0;
      irq_src    <= SRC_NONE;
    end else begin
      latch      <= (EDGE_MASK & rst_rise) | (latch & ~clr_c);
      trap_latch <= trap_rise | (trap_latch & ~trap_ack_c);
      arm        <= arm_n_c;
      ie         <= ie_n_c;
      if (trap_ack_c) ie_saved <= ie;
      if (mask_wr)    mask     <= mask_in;
      if (sod_wr)     sod      <= sod_in;
      irq        <= (win_src_c != SRC_NONE);
      irq_vec    <= win_vec_c;
      irq_intr   <= win_intr_c;
      irq_src    <= win_src_c;
    end
  end

  assign pending = (EDGE_MASK & latch) | (~EDGE_MASK & rst_lvl);
  assign sid_s   = sid_lvl;

endmodule

// File: doc/intctl85.md
Name: intctl85

Overview:
- Parametrised interrupt and serial-pin controller for the 8085-class core; next generation of the interrupt logic behind the core top.
- Adds what the current top ties off: TRAP, N vectored RST lines (default 5.5/6.5/7.5), INTR, SIM/RIM-style mask and status, SID/SOD.
- Sits between the core pins and the control sequencer.
- Resolves priority and presents one registered request plus its vector address; the sequencer samples it at instruction boundaries.

Parameters:
- NUM_RST, 3, number of vectored maskable RST lines; index 0 has the lowest priority.
- EDGE_MASK, 3'b100, per-line mode: 1 = rising-edge latched, 0 = level.
- SYNC_STAGES, 2, synchroniser depth for all asynchronous pins (minimum 2).
- ADDRSIZE, 16, vector width.
- TRAP_VEC, 16'h0024, TRAP vector address.
- RST_BASE, 16'h002C, vector address of RST line 0.
- RST_STEP, 8, vector spacing between consecutive RST lines.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- trap, input, 1: async, non-maskable, edge-and-level sensitive.
- rst_in, input, NUM_RST: async vectored lines.
- intr, input, 1: async, level; vector is supplied externally during INTA.
- sid, input, 1: async serial in.
- inst_done, input, 1: one-cycle pulse at each instruction boundary.
- ei / di, input, 1 each: one-cycle pulses from EI/DI execution.
- mask_wr, input, 1: SIM mask-write strobe.
- mask_in, input, NUM_RST: new mask; 1 = masked.
- edge_clr, input, NUM_RST: with mask_wr, clears the selected edge latches.
- sod_wr / sod_in, input, 1 each: SOD write strobe and data.
- ack, input, 1: sequencer accepts the presented request.
- irq, output, 1: request pending (registered).
- irq_vec, output, ADDRSIZE: vector of the presented request.
- irq_intr, output, 1: presented source is INTR, so the sequencer runs an INTA cycle.
- ie, output, 1: interrupt-enable flag.
- ie_saved, output, 1: ie value captured on the last TRAP acknowledge.
- mask, output, NUM_RST: current mask.
- pending, output, NUM_RST: raw pending per line (RIM).
- sid_s, output, 1: synchronised sid.
- sod, output, 1: serial out latch.

Behaviour:
- Reset: mask all ones, ie 0, ie_saved 0, all latches 0, sod 0, irq 0, irq_vec 0, irq_intr 0; synchroniser flops 0. Reset mid-request drops irq on the next cycle. Reset has priority over every strobe.
- Synchronisation: every async pin passes SYNC_STAGES flops, then a one-flop edge detector (sync_edge).
- Edge lines (EDGE_MASK=1): the latch sets on a synced rising edge whatever the mask or ie. It clears on ack of that line, or on mask_wr with edge_clr set. A set and a clear in the same cycle leave the latch set, so no event is lost. pending = latch.
- Level lines: pending = synced level.
- TRAP: latch sets on a synced rising edge. The request is latch AND synced level. The latch clears on TRAP ack.
- Eligibility: TRAP is always eligible. RST line i is eligible when pending[i] & ~mask[i] & ie. INTR is eligible when synced intr & ie.
- Priority: TRAP > rst_in[NUM_RST-1] > ... > rst_in[0] > INTR.
- Request register: irq, irq_vec and irq_intr update every cycle from the resolved winner.
  - Vectors: TRAP → TRAP_VEC; RST i → RST_BASE + i*RST_STEP, truncated to ADDRSIZE; INTR → 0 with irq_intr=1.
- Latency: a pin rising before edge k gives irq high after edge k+SYNC_STAGES+1. With the default this is 3 cycles; a test-plan value of 4 means the pin rose just after edge k.
- ack:
  - Acts on the request presented in that cycle; ack with irq=0 is ignored.
  - Clears the edge latch of the acked source. Level sources are not cleared.
  - Clears ie. On a TRAP ack, ie_saved captures ie first.
  - irq deasserts the following cycle unless another source is eligible. Only TRAP stays eligible then, because ie is 0.
- EI: sets an arm flag; ie goes to 1 on the first inst_done strictly after the ei pulse. ei and inst_done in the same cycle arm only.
- DI: clears ie and the arm flag immediately. di wins over ei in the same cycle. di and ack in the same cycle leave ie 0.
- mask_wr: mask <= mask_in next cycle. Masking does not affect latch setting.
- sod_wr: sod <= sod_in. It is independent of all interrupt state.

Decomposition:
- Package intctl85_pkg holds:
  - source encoding (SRC_NONE, SRC_TRAP, SRC_RST0.., SRC_INTR) as localparams;
  - the default vector constants;
  - the function computing the RST vector from an index.
- One sub-module, sync_edge: SYNC_STAGES synchroniser plus rising-edge detector, outputs level_s and rise. Instantiated NUM_RST+3 times (trap, intr, sid, each rst_in).

Test Plan:
- Reset, then rst_in=3'b100 (7.5) with ie=1 and mask=3'b011 → irq=1 after 4 cycles, irq_vec=16'h003C; ack → irq=0 next cycle, pending[2]=0, ie=0.
- rst_in[2] pulses while mask=3'b111, then mask_wr mask_in=3'b000 and EI + inst_done → pending[2] holds 1 throughout; irq with 16'h003C once ie=1.
- Level rst_in[0] and rst_in[1] both high, ie=1, mask=0 → irq_vec=16'h0034; ack, release rst_in[1], EI + inst_done → irq_vec=16'h002C.
- trap rising edge with ie=1, then trap falls before ack → irq drops (latch set, level low); trap high again → irq_vec=16'h0024; ack → ie=0, ie_saved=1.
- ei, then inst_done 3 cycles later, intr held high → ie=0 until the cycle after inst_done; then irq=1, irq_intr=1; di in the same cycle as a second ei → ie stays 0.
- Non-default NUM_RST=5, EDGE_MASK=5'b10001: edge on rst_in[4] and level on rst_in[3] simultaneously → irq_vec=16'h004C first; after ack, 16'h0044.
